// File: rtl/ttl373_seq_pkg.sv
// Shared definitions for the 74LS373 bus sequencer and sibling bus-control blocks:
// state encodings and index-width helpers.
package ttl373_seq_pkg;

    localparam logic [2:0] ENC_IDLE  = 3'd0;
    localparam logic [2:0] ENC_DRIVE = 3'd1;
    localparam logic [2:0] ENC_LATCH = 3'd2;
    localparam logic [2:0] ENC_HOLD  = 3'd3;
    localparam logic [2:0] ENC_TURN  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ENC_IDLE,
        DRIVE = ENC_DRIVE,
        LATCH = ENC_LATCH,
        HOLD  = ENC_HOLD,
        TURN  = ENC_TURN
    } seq_state_e;

    // Index width for n items; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ttl_rr_arbiter.sv
// Combinational N-way round-robin arbiter: searches ptr+1 .. ptr (mod N) and
// returns the first requester as a one-hot grant and as an index.
module ttl_rr_arbiter
    import ttl373_seq_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          valid
);

    logic [IW-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        cand      = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IW'((32'(ptr) + k) % N);
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ttl373_bus_sequencer.sv
// Round-robin sequencer for 74LS373 latches sharing one tri-state bus; generates
// OE_n/LE strobes with settle/latch/hold/turnaround phases. Optional FAULT output
// and protocol checks are enabled with TTL373_SEQ_PROTOCOL_CHECK_EN.
module ttl373_bus_sequencer
    import ttl373_seq_pkg::*;
#(
    parameter int unsigned N             = 4,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned LE_CYCLES     = 1,
    parameter int unsigned HOLD_CYCLES   = 1
) (
    input  logic                      CLK,
    input  logic                      RESET_n,
    input  logic [N-1:0]              REQ,
    input  logic [N*idx_width(N)-1:0] DEST,
    output logic [N-1:0]              OE_n,
    output logic [N-1:0]              LE,
    output logic [N-1:0]              ACK,
`ifdef TTL373_SEQ_PROTOCOL_CHECK_EN
    output logic                      BUSY,
    output logic                      FAULT
`else
    output logic                      BUSY
`endif
);

    localparam int unsigned IW   = idx_width(N);
    localparam int unsigned MAXC = max3(SETTLE_CYCLES, LE_CYCLES, HOLD_CYCLES);
    localparam int unsigned CW   = idx_width(MAXC);

    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] LE_LD     = CW'(LE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES - 1);

    seq_state_e    state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [IW-1:0] ptr, ptr_d;
    logic [IW-1:0] src, src_d;
    logic [IW-1:0] dst, dst_d;
    logic          strobe, strobe_d;
    logic [N-1:0]  oe_n_d, le_d, ack_d;
    logic          busy_d;

    logic [N-1:0]  gnt_oh;
    logic [IW-1:0] gnt_idx;
    logic          gnt_valid;
    logic [IW-1:0] dest_sel;

    ttl_rr_arbiter #(.N(N), .IW(IW)) u_arb (
        .req       (REQ),
        .ptr       (ptr),
        .grant     (gnt_oh),
        .grant_idx (gnt_idx),
        .valid     (gnt_valid)
    );

    // Destination of the would-be grantee, muxed by the one-hot grant.
    always_comb begin
        dest_sel = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt_oh[i]) dest_sel = dest_sel | DEST[i*IW +: IW];
        end
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state  <= IDLE;
            cnt    <= '0;
            ptr    <= IW'(N - 1);
            src    <= '0;
            dst    <= '0;
            strobe <= 1'b0;
            OE_n   <= '1;
            LE     <= '0;
            ACK    <= '0;
            BUSY   <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            ptr    <= ptr_d;
            src    <= src_d;
            dst    <= dst_d;
            strobe <= strobe_d;
            OE_n   <= oe_n_d;
            LE     <= le_d;
            ACK    <= ack_d;
            BUSY   <= busy_d;
        end
    end

    // Next state plus next output values, decoded from the state being entered.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        ptr_d    = ptr;
        src_d    = src;
        dst_d    = dst;
        strobe_d = strobe;
        oe_n_d   = '1;
        le_d     = '0;
        ack_d    = '0;
        busy_d   = 1'b0;

        case (state)
            IDLE, TURN: begin
                if (gnt_valid) begin
                    state_d  = DRIVE;
                    cnt_d    = SETTLE_LD;
                    ptr_d    = gnt_idx;
                    src_d    = gnt_idx;
                    dst_d    = dest_sel;
                    // Self-transfers and out-of-range destinations run with no strobes.
                    strobe_d = (32'(dest_sel) < N) && (dest_sel != gnt_idx);
                end else begin
                    state_d = IDLE;
                end
            end
            DRIVE: begin
                if (cnt == '0) begin
                    state_d = LATCH;
                    cnt_d   = LE_LD;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            LATCH: begin
                if (cnt == '0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_d = TURN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        if (strobe_d && (state_d == DRIVE || state_d == LATCH || state_d == HOLD))
            oe_n_d[src_d] = 1'b0;
        if (strobe_d && state_d == LATCH)
            le_d[dst_d] = 1'b1;
        if (state_d == TURN)
            ack_d[src_d] = 1'b1;
    end

`ifdef TTL373_SEQ_PROTOCOL_CHECK_EN
    logic [IW-1:0] cur_dest;
    logic          cur_req;
    logic          violation;

    // The active requester must hold REQ and a stable DEST until its ACK.
    always_comb begin
        cur_dest = '0;
        cur_req  = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (src == IW'(i)) begin
                cur_dest = DEST[i*IW +: IW];
                cur_req  = REQ[i];
            end
        end
        violation = (state == DRIVE || state == LATCH || state == HOLD) &&
                    (!cur_req || cur_dest != dst);
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n)       FAULT <= 1'b0;
        else if (violation) FAULT <= 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RESET_n && violation)
            $error("ttl373_bus_sequencer: protocol violation by requester %0d", src);
    end
`endif

endmodule

// File: tb/tb_ttl373_bus_sequencer.sv
// Directed scoreboard bench for ttl373_bus_sequencer: default timing instance plus
// a SETTLE=3/LE=2/HOLD=2 instance, checked cycle by cycle against queued expectations.
module tb_ttl373_bus_sequencer;

    typedef struct packed {
        logic [3:0] oe_n;
        logic [3:0] le;
        logic [3:0] ack;
        logic       busy;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_a, req_b;
    logic [7:0] dest_a, dest_b;
    logic [3:0] oe_n_a, le_a, ack_a, oe_n_b, le_b, ack_b;
    logic       busy_a, busy_b;
`ifdef TTL373_SEQ_PROTOCOL_CHECK_EN
    logic       fault_a, fault_b;
`endif

    obs_t exp_a[$];
    obs_t exp_b[$];
    int   errors = 0;
    int   checks = 0;
    bit   hold_req = 1'b0;

    always #5 clk = ~clk;

    ttl373_bus_sequencer #(.N(4), .SETTLE_CYCLES(2), .LE_CYCLES(1), .HOLD_CYCLES(1)) dut_a (
        .CLK(clk), .RESET_n(rst_n), .REQ(req_a), .DEST(dest_a),
        .OE_n(oe_n_a), .LE(le_a), .ACK(ack_a),
`ifdef TTL373_SEQ_PROTOCOL_CHECK_EN
        .BUSY(busy_a), .FAULT(fault_a)
`else
        .BUSY(busy_a)
`endif
    );

    ttl373_bus_sequencer #(.N(4), .SETTLE_CYCLES(3), .LE_CYCLES(2), .HOLD_CYCLES(2)) dut_b (
        .CLK(clk), .RESET_n(rst_n), .REQ(req_b), .DEST(dest_b),
        .OE_n(oe_n_b), .LE(le_b), .ACK(ack_b),
`ifdef TTL373_SEQ_PROTOCOL_CHECK_EN
        .BUSY(busy_b), .FAULT(fault_b)
`else
        .BUSY(busy_b)
`endif
    );

    function automatic obs_t mk(input logic [3:0] oe_n, input logic [3:0] le,
                                input logic [3:0] ack, input logic busy);
        return {oe_n, le, ack, busy};
    endfunction

    function automatic obs_t obs_a();
        return {oe_n_a, le_a, ack_a, busy_a};
    endfunction

    function automatic obs_t obs_b();
        return {oe_n_b, le_b, ack_b, busy_b};
    endfunction

    task automatic push(input bit sel, input obs_t o);
        if (sel) exp_b.push_back(o);
        else     exp_a.push_back(o);
    endtask

    task automatic push_idle(input bit sel, input int n);
        for (int i = 0; i < n; i++) push(sel, mk(4'hF, 4'h0, 4'h0, 1'b0));
    endtask

    // Expected trace of one transfer: settle, latch, hold, then one turnaround cycle with ACK.
    task automatic push_xfer(input bit sel, input int s, input int d, input bit st,
                             input int settle, input int lec, input int hold);
        logic [3:0] oe, lev, ak;
        oe  = st ? ~(4'b0001 << s) : 4'hF;
        lev = st ? (4'b0001 << d) : 4'h0;
        ak  = 4'b0001 << s;
        for (int i = 0; i < settle; i++) push(sel, mk(oe, 4'h0, 4'h0, 1'b1));
        for (int i = 0; i < lec; i++)    push(sel, mk(oe, lev, 4'h0, 1'b1));
        for (int i = 0; i < hold; i++)   push(sel, mk(oe, 4'h0, 4'h0, 1'b1));
        push(sel, mk(4'hF, 4'h0, ak, 1'b1));
    endtask

    task automatic check(input string tag, input obs_t observed, input obs_t expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed oe_n/le/ack/busy=%h/%h/%h/%b expected=%h/%h/%h/%b", tag,
                   observed.oe_n, observed.le, observed.ack, observed.busy,
                   expected.oe_n, expected.le, expected.ack, expected.busy);
        end
    endtask

    task automatic check_bit(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Advance n cycles, popping one expectation per cycle; requesters drop REQ on ACK unless held.
    task automatic run(input bit sel, input int n, input string tag);
        obs_t o, e;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            o = sel ? obs_b() : obs_a();
            if ((sel && exp_b.size() == 0) || (!sel && exp_a.size() == 0)) begin
                checks++;
                errors++;
                $error("FAIL %s[%0d]: scoreboard empty, observed=%h expected=queued entry", tag, c, o);
            end else begin
                if (sel) e = exp_b.pop_front();
                else     e = exp_a.pop_front();
                check($sformatf("%s[%0d]", tag, c), o, e);
            end
            if (!hold_req) begin
                req_a = req_a & ~ack_a;
                req_b = req_b & ~ack_b;
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        req_a  = 4'h0;
        req_b  = 4'h0;
        dest_a = 8'h00;
        dest_b = 8'h00;

        @(posedge clk);
        #1;
        check("reset_a", obs_a(), mk(4'hF, 4'h0, 4'h0, 1'b0));
        check("reset_b", obs_b(), mk(4'hF, 4'h0, 4'h0, 1'b0));
`ifdef TTL373_SEQ_PROTOCOL_CHECK_EN
        check_bit("reset_fault", fault_a, 1'b0);
`endif
        @(negedge clk) rst_n = 1'b1;

        // Single transfer 0 -> 3.
        @(negedge clk);
        req_a  = 4'b0001;
        dest_a = 8'b00_00_00_11;
        push_xfer(1'b0, 0, 3, 1'b1, 2, 1, 1);
        push_idle(1'b0, 2);
        run(1'b0, 7, "single");

        // Self-transfer 2 -> 2: no strobes, same latency.
        @(negedge clk);
        req_a  = 4'b0100;
        dest_a = 8'b00_10_00_00;
        push_xfer(1'b0, 2, 2, 1'b0, 2, 1, 1);
        push_idle(1'b0, 2);
        run(1'b0, 7, "self");

        // Asynchronous reset in the middle of DRIVE.
        @(negedge clk);
        req_a  = 4'b0010;
        dest_a = 8'b00_00_10_00;
        push(1'b0, mk(4'b1101, 4'h0, 4'h0, 1'b1));
        push(1'b0, mk(4'b1101, 4'h0, 4'h0, 1'b1));
        run(1'b0, 2, "pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", obs_a(), mk(4'hF, 4'h0, 4'h0, 1'b0));
        req_a = 4'h0;
        @(negedge clk) rst_n = 1'b1;

        // Contention from fresh reset: grant order 0,1,3,0 with one idle bus cycle between.
        @(negedge clk);
        hold_req = 1'b1;
        req_a    = 4'b1011;
        dest_a   = 8'b00_00_11_10;
        push_xfer(1'b0, 0, 2, 1'b1, 2, 1, 1);
        push_xfer(1'b0, 1, 3, 1'b1, 2, 1, 1);
        push_xfer(1'b0, 3, 0, 1'b1, 2, 1, 1);
        push_xfer(1'b0, 0, 2, 1'b1, 2, 1, 1);
        run(1'b0, 20, "rr");
        req_a    = 4'h0;
        hold_req = 1'b0;
        push_idle(1'b0, 2);
        run(1'b0, 2, "rr_end");
`ifdef TTL373_SEQ_PROTOCOL_CHECK_EN
        check_bit("no_fault", fault_a, 1'b0);
`endif

        // Longer phases: LE high 2 cycles starting 3 after OE_n falls, ACK at cycle 7.
        @(negedge clk);
        req_b  = 4'b0001;
        dest_b = 8'b00_00_00_10;
        push_xfer(1'b1, 0, 2, 1'b1, 3, 2, 2);
        push_idle(1'b1, 2);
        run(1'b1, 10, "sweep");

`ifdef TTL373_SEQ_PROTOCOL_CHECK_EN
        // Requester 1 drops REQ during LATCH: transfer still completes, FAULT sticks.
        @(negedge clk);
        req_a  = 4'b0010;
        dest_a = 8'h00;
        push_xfer(1'b0, 1, 0, 1'b1, 2, 1, 1);
        push_idle(1'b0, 2);
        run(1'b0, 3, "fault_xfer");
        req_a = 4'h0;
        run(1'b0, 4, "fault_tail");
        check_bit("fault_set", fault_a, 1'b1);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check_bit("fault_cleared", fault_a, 1'b0);
        @(negedge clk) rst_n = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

endmodule
